// File: rtl/cvxif_issue_pkg.sv
// Shared types for the CV-X-IF issue master: payload structs and FSM state.
// Struct widths follow the localparams below; change them here when resizing.
package cvxif_issue_pkg;

  localparam int unsigned NR_OUT = 4;
  localparam int unsigned XLEN_W = 32;
  localparam int unsigned ID_W   = $clog2(NR_OUT);

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN_W-1:0] rs1;
    logic [XLEN_W-1:0] rs2;
    logic [ID_W-1:0]   id;
  } issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } issue_resp_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [4:0]        rd;
    logic [XLEN_W-1:0] data;
  } result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/cvxif_issue_master_if.sv
// Core request/response, CV-X-IF issue/result and core writeback signals.
// master = the issue master itself, slave = core + coprocessor side.
interface cvxif_issue_master_if #(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned IdWidth       = $clog2(NrOutstanding)
);
  logic               core_req_valid_i;
  logic               core_req_ready_o;
  logic [31:0]        core_instr_i;
  logic [XLEN-1:0]    core_rs1_i;
  logic [XLEN-1:0]    core_rs2_i;
  logic               core_resp_valid_o;
  logic               core_resp_accept_o;
  logic               core_resp_writeback_o;
  logic [IdWidth-1:0] core_resp_id_o;
  logic               x_issue_valid_o;
  logic               x_issue_ready_i;
  logic [31:0]        x_issue_instr_o;
  logic [XLEN-1:0]    x_issue_rs1_o;
  logic [XLEN-1:0]    x_issue_rs2_o;
  logic [IdWidth-1:0] x_issue_id_o;
  logic               x_issue_accept_i;
  logic               x_issue_writeback_i;
  logic               x_result_valid_i;
  logic               x_result_ready_o;
  logic [IdWidth-1:0] x_result_id_i;
  logic [4:0]         x_result_rd_i;
  logic [XLEN-1:0]    x_result_data_i;
  logic               core_wb_valid_o;
  logic [IdWidth-1:0] core_wb_id_o;
  logic [4:0]         core_wb_rd_o;
  logic [XLEN-1:0]    core_wb_data_o;
  logic [IdWidth:0]   busy_o;
  logic               err_o;

  modport master (
    input  core_req_valid_i, core_instr_i, core_rs1_i, core_rs2_i,
           x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
           x_result_valid_i, x_result_id_i, x_result_rd_i, x_result_data_i,
    output core_req_ready_o, core_resp_valid_o, core_resp_accept_o,
           core_resp_writeback_o, core_resp_id_o,
           x_issue_valid_o, x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o, x_issue_id_o,
           x_result_ready_o, core_wb_valid_o, core_wb_id_o, core_wb_rd_o, core_wb_data_o,
           busy_o, err_o
  );

  modport slave (
    output core_req_valid_i, core_instr_i, core_rs1_i, core_rs2_i,
           x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
           x_result_valid_i, x_result_id_i, x_result_rd_i, x_result_data_i,
    input  core_req_ready_o, core_resp_valid_o, core_resp_accept_o,
           core_resp_writeback_o, core_resp_id_o,
           x_issue_valid_o, x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o, x_issue_id_o,
           x_result_ready_o, core_wb_valid_o, core_wb_id_o, core_wb_rd_o, core_wb_data_o,
           busy_o, err_o
  );
endinterface

// File: rtl/cvxif_id_alloc.sv
// Outstanding-ID tracker: bit vector with set/clear, lowest-free pick and
// a registered population count.
module cvxif_id_alloc #(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned IdWidth       = $clog2(NrOutstanding)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     set_i,
  input  logic [IdWidth-1:0]       set_id_i,
  input  logic                     clr_i,
  input  logic [IdWidth-1:0]       clr_id_i,
  output logic [NrOutstanding-1:0] outstanding_o,
  output logic                     free_o,
  output logic [IdWidth-1:0]       free_id_o,
  output logic [IdWidth:0]         busy_o
);

  logic [NrOutstanding-1:0] vec_q, vec_d;
  logic [IdWidth:0]         busy_q, busy_d;

  // Set is applied after clear so a same-edge set always wins.
  always_comb begin
    vec_d = vec_q;
    if (clr_i) vec_d[clr_id_i] = 1'b0;
    if (set_i) vec_d[set_id_i] = 1'b1;
    busy_d = '0;
    for (int i = 0; i < NrOutstanding; i++)
      busy_d = busy_d + (IdWidth+1)'(vec_d[i]);
  end

  // Pick from the registered vector so an ID freed this edge is not reused yet.
  always_comb begin
    free_id_o = '0;
    free_o    = 1'b0;
    for (int i = NrOutstanding - 1; i >= 0; i--) begin
      if (!vec_q[i]) begin
        free_id_o = IdWidth'(i);
        free_o    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_q  <= '0;
      busy_q <= '0;
    end else begin
      vec_q  <= vec_d;
      busy_q <= busy_d;
    end
  end

  assign outstanding_o = vec_q;
  assign busy_o        = busy_q;

endmodule

// File: rtl/cvxif_issue_master.sv
// Core-side CV-X-IF initiator: offers one instruction at a time on the issue
// channel, reports the decision to the core and forwards results by ID.
module cvxif_issue_master
  import cvxif_issue_pkg::*;
#(
  parameter int unsigned NrOutstanding = NR_OUT,
  parameter int unsigned XLEN          = XLEN_W,
  parameter int unsigned IdWidth       = $clog2(NrOutstanding)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cvxif_issue_master_if.master bus
);

  state_e      state_q, state_d;
  issue_req_t  req_q, req_d;
  issue_resp_t resp_q, resp_d;
  logic        issue_valid_q, issue_valid_d;
  logic        resp_valid_q, resp_valid_d;

  result_t     wb_q, wb_d, res_in;
  logic        wb_valid_q, wb_valid_d;
  logic        err_q, err_d;
  logic        res_ready_q;

  logic [NrOutstanding-1:0] outstanding;
  logic                     free_any;
  logic [IdWidth-1:0]       free_id;
  logic [IdWidth:0]         busy;
  logic req_ready, core_hs, issue_hs, set_wb, res_take, res_hit;

  assign req_ready = (state_q == IDLE) && free_any;
  assign core_hs   = bus.core_req_valid_i && req_ready;
  assign issue_hs  = issue_valid_q && bus.x_issue_ready_i;
  assign set_wb    = issue_hs && bus.x_issue_accept_i && bus.x_issue_writeback_i;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    resp_d        = resp_q;
    issue_valid_d = issue_valid_q;
    resp_valid_d  = 1'b0;
    case (state_q)
      IDLE: if (core_hs) begin
        req_d = '{instr: bus.core_instr_i, rs1: bus.core_rs1_i,
                  rs2: bus.core_rs2_i, id: free_id};
        issue_valid_d = 1'b1;
        state_d       = ISSUE;
      end
      ISSUE: if (issue_hs) begin
        // A rejected instruction never produces a result, whatever writeback says.
        resp_d.accept    = bus.x_issue_accept_i;
        resp_d.writeback = bus.x_issue_accept_i && bus.x_issue_writeback_i;
        issue_valid_d    = 1'b0;
        resp_valid_d     = 1'b1;
        state_d          = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      req_q         <= '0;
      resp_q        <= '0;
      issue_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      resp_q        <= resp_d;
      issue_valid_q <= issue_valid_d;
      resp_valid_q  <= resp_valid_d;
    end
  end

  // Result path runs independently of the issue FSM.
  assign res_in   = '{id: bus.x_result_id_i, rd: bus.x_result_rd_i, data: bus.x_result_data_i};
  assign res_take = bus.x_result_valid_i && res_ready_q;
  assign res_hit  = res_take && outstanding[res_in.id];

  always_comb begin
    wb_d       = wb_q;
    wb_valid_d = res_hit;
    err_d      = err_q || (res_take && !res_hit);
    if (res_hit) wb_d = res_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q        <= '0;
      wb_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      res_ready_q <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      wb_valid_q  <= wb_valid_d;
      err_q       <= err_d;
      res_ready_q <= 1'b1;
    end
  end

  cvxif_id_alloc #(
    .NrOutstanding (NrOutstanding),
    .IdWidth       (IdWidth)
  ) u_id_alloc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .set_i         (set_wb),
    .set_id_i      (req_q.id),
    .clr_i         (res_hit),
    .clr_id_i      (res_in.id),
    .outstanding_o (outstanding),
    .free_o        (free_any),
    .free_id_o     (free_id),
    .busy_o        (busy)
  );

  assign bus.core_req_ready_o      = req_ready;
  assign bus.core_resp_valid_o     = resp_valid_q;
  assign bus.core_resp_accept_o    = resp_q.accept;
  assign bus.core_resp_writeback_o = resp_q.writeback;
  assign bus.core_resp_id_o        = req_q.id;
  assign bus.x_issue_valid_o       = issue_valid_q;
  assign bus.x_issue_instr_o       = req_q.instr;
  assign bus.x_issue_rs1_o         = req_q.rs1;
  assign bus.x_issue_rs2_o         = req_q.rs2;
  assign bus.x_issue_id_o          = req_q.id;
  assign bus.x_result_ready_o      = res_ready_q;
  assign bus.core_wb_valid_o       = wb_valid_q;
  assign bus.core_wb_id_o          = wb_q.id;
  assign bus.core_wb_rd_o          = wb_q.rd;
  assign bus.core_wb_data_o        = wb_q.data;
  assign bus.busy_o                = busy;
  assign bus.err_o                 = err_q;

endmodule

// File: tb/tb_cvxif_issue_master.sv
// Self-checking bench for cvxif_issue_master: directed scenarios followed by
// a randomized issue/result mix against a transaction-level ID model.
module tb_cvxif_issue_master;

  localparam int NOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cvxif_issue_master_if #(.NrOutstanding(NOUT), .XLEN(32)) bus ();

  cvxif_issue_master #(.NrOutstanding(NOUT), .XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: which IDs hold a pending result, and the sticky error flag.
  bit mdl_out [NOUT];
  bit mdl_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_lowest();
    for (int i = 0; i < NOUT; i++) if (!mdl_out[i]) return i;
    return -1;
  endfunction

  function automatic int mdl_busy();
    int c = 0;
    for (int i = 0; i < NOUT; i++) c += int'(mdl_out[i]);
    return c;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NOUT; i++) mdl_out[i] = 1'b0;
    mdl_err = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.core_req_valid_i    = 1'b0;
    bus.core_instr_i        = '0;
    bus.core_rs1_i          = '0;
    bus.core_rs2_i          = '0;
    bus.x_issue_ready_i     = 1'b0;
    bus.x_issue_accept_i    = 1'b0;
    bus.x_issue_writeback_i = 1'b0;
    bus.x_result_valid_i    = 1'b0;
    bus.x_result_id_i       = '0;
    bus.x_result_rd_i       = '0;
    bus.x_result_data_i     = '0;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input int stall, input bit acc, input bit wb);
    int eid;
    eid = mdl_lowest();
    chk("req_ready", bus.core_req_ready_o, 1);
    bus.core_req_valid_i = 1'b1;
    bus.core_instr_i = ins; bus.core_rs1_i = r1; bus.core_rs2_i = r2;
    @(posedge clk); #1;
    bus.core_req_valid_i = 1'b0;
    bus.core_instr_i = $urandom; bus.core_rs1_i = $urandom; bus.core_rs2_i = $urandom;
    for (int s = 0; s <= stall; s++) begin
      chk("iss_valid", bus.x_issue_valid_o, 1);
      chk("iss_instr_rs1", {bus.x_issue_instr_o, bus.x_issue_rs1_o}, {ins, r1});
      chk("iss_rs2_id", {bus.x_issue_rs2_o, 30'd0, bus.x_issue_id_o}, {r2, 30'd0, 2'(eid)});
      chk("resp_idle", bus.core_resp_valid_o, 0);
      if (s < stall) begin
        bus.x_issue_accept_i = 1'($urandom); bus.x_issue_writeback_i = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.x_issue_ready_i = 1'b1; bus.x_issue_accept_i = acc; bus.x_issue_writeback_i = wb;
    @(posedge clk); #1;
    bus.x_issue_ready_i = 1'b0;
    bus.x_issue_accept_i = 1'($urandom); bus.x_issue_writeback_i = 1'($urandom);
    if (acc && wb) mdl_out[eid] = 1'b1;
    chk("iss_drop", bus.x_issue_valid_o, 0);
    chk("resp", {bus.core_resp_valid_o, bus.core_resp_accept_o, bus.core_resp_writeback_o},
        {1'b1, acc, acc && wb});
    chk("resp_id", bus.core_resp_id_o, eid);
    chk("busy", bus.busy_o, mdl_busy());
    @(posedge clk); #1;
    chk("resp_pulse", bus.core_resp_valid_o, 0);
  endtask

  task automatic result(input int id, input logic [4:0] rd, input logic [31:0] data);
    bit hit;
    hit = mdl_out[id];
    bus.x_result_valid_i = 1'b1;
    bus.x_result_id_i = 2'(id); bus.x_result_rd_i = rd; bus.x_result_data_i = data;
    @(posedge clk); #1;
    bus.x_result_valid_i = 1'b0;
    bus.x_result_data_i = $urandom;
    chk("wb_valid", bus.core_wb_valid_o, hit);
    if (hit) begin
      chk("wb_id_rd", {bus.core_wb_id_o, bus.core_wb_rd_o}, {2'(id), rd});
      chk("wb_data", bus.core_wb_data_o, data);
      mdl_out[id] = 1'b0;
    end else mdl_err = 1'b1;
    chk("err", bus.err_o, mdl_err);
    chk("busy", bus.busy_o, mdl_busy());
    @(posedge clk); #1;
    chk("wb_pulse", bus.core_wb_valid_o, 0);
  endtask

  task automatic chk_reset_state();
    chk("rst_outs", {bus.x_issue_valid_o, bus.core_resp_valid_o, bus.core_wb_valid_o,
                     bus.err_o, bus.x_result_ready_o}, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_data", {bus.x_issue_instr_o, bus.core_wb_data_o}, 0);
  endtask

  initial begin
    int j, k;
    idle_inputs();
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("res_ready", bus.x_result_ready_o, 1);

    // Accept without writeback: ID 0, nothing retained.
    issue(32'h0000_002B, 32'd5, 32'd7, 0, 1'b1, 1'b0);
    // Accept with writeback under a 3-cycle stall, then its result.
    issue(32'h0600_0033, $urandom, $urandom, 3, 1'b1, 1'b1);
    result(0, 5'd10, 32'hDEAD_BEEF);

    // Fill all IDs, then confirm the core is held off.
    for (int i = 0; i < NOUT; i++) issue($urandom, $urandom, $urandom, 0, 1'b1, 1'b1);
    chk("full_ready", bus.core_req_ready_o, 0);
    bus.core_req_valid_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("full_no_issue", bus.x_issue_valid_o, 0);
    end
    bus.core_req_valid_i = 1'b0;
    result(2, 5'd3, 32'h1234_5678);
    issue($urandom, $urandom, $urandom, 1, 1'b1, 1'b1);
    for (int i = 0; i < NOUT; i++) result(i, 5'(i + 1), $urandom);

    // Rejection with writeback set is reported as no writeback.
    issue(32'h0000_1073, $urandom, $urandom, 2, 1'b0, 1'b1);
    chk("rej_busy", bus.busy_o, 0);

    // Result for an ID that is not outstanding.
    result(3, 5'd7, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", bus.err_o, 1);

    // Reset mid-issue with one ID outstanding.
    issue($urandom, $urandom, $urandom, 0, 1'b1, 1'b1);
    bus.core_req_valid_i = 1'b1; bus.core_instr_i = $urandom;
    @(posedge clk); #1;
    bus.core_req_valid_i = 1'b0;
    chk("pre_rst_valid", bus.x_issue_valid_o, 1);
    chk("pre_rst_id", bus.x_issue_id_o, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_clear();
    @(posedge clk); #1;
    chk("post_rst_busy", bus.busy_o, 0);
    issue($urandom, $urandom, $urandom, 0, 1'b1, 1'b0);

    // Randomized mix of issues and results.
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 3));
      if (k < 2 && mdl_lowest() >= 0)
        issue($urandom, $urandom, $urandom, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 3) != 0), 1'($urandom));
      else if (k < 3 && mdl_busy() > 0) begin
        do j = int'($urandom_range(0, NOUT - 1)); while (!mdl_out[j]);
        result(j, 5'($urandom), $urandom);
      end else if (mdl_lowest() < 0)
        chk("rand_full", bus.core_req_ready_o, 0);
      else
        result(int'($urandom_range(0, NOUT - 1)), 5'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
